// File: rtl/smem_pkg.sv
// smem_pkg: shared constants and types for the SMEM read store.
// Status codes, row field offsets and the dispatch state encoding.
package smem_pkg;

    typedef logic [7:0] sym_t;

    localparam logic [5:0] ST_F_BREAK = 6'd2;
    localparam logic [5:0] ST_DONE    = 6'h3F;

    localparam int PAR_FWD_LSB = 0;
    localparam int PAR_FWD_W   = 7;
    localparam int PAR_PRI_LSB = 128;
    localparam int PAR_PRI_W   = 64;

    localparam int IK_ROW_W    = 256;
    localparam int IK_L2_LSB   = 256;
    localparam int IK_L2_W     = 256;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_FETCH,
        DS_SHOW,
        DS_DONE
    } disp_state_e;

endpackage

// File: rtl/smem_read_store_lane.sv
// smem_query_lane: 3-stage symbol extractor (row, 64-bit word, byte)
// serving one query channel from a shared symbol RAM read port.
module smem_query_lane
    import smem_pkg::*;
#(
    parameter int CL      = 512,
    parameter int MAX_LEN = 128,
    parameter int RN_W    = 9,
    parameter int RB      = 2,
    parameter int ROW_W   = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [RN_W:0]    batch_size,
    input  logic             q_valid,
    input  logic [5:0]       q_status,
    input  logic [7:0]       q_pos,
    input  logic [RN_W-1:0]  q_read_num,
    output logic [ROW_W-1:0] row_addr,
    input  logic [CL-1:0]    row_data,
    output logic             q_out_valid,
    output sym_t             q_out_sym,
    output logic [7:0]       q_out_pos
);

    localparam int SYM_ROW = CL / 8;
    localparam int COL_W   = $clog2(SYM_ROW);
    localparam int POS_W   = $clog2(MAX_LEN);

    logic [POS_W-1:0] pos_in;
    logic             issue;
    logic             oor;

    logic             s1_v_q, s1_v_d;
    logic             s1_oor_q, s1_oor_d;
    logic [7:0]       s1_pos_q, s1_pos_d;
    logic [CL-1:0]    s1_row_q, s1_row_d;

    logic             s2_v_q, s2_v_d;
    logic             s2_oor_q, s2_oor_d;
    logic [7:0]       s2_pos_q, s2_pos_d;
    logic [63:0]      s2_word_q, s2_word_d;

    logic             out_v_q, out_v_d;
    sym_t             out_sym_q, out_sym_d;
    logic [7:0]       out_pos_q, out_pos_d;

    assign pos_in   = q_pos[POS_W-1:0];
    assign row_addr = ROW_W'(int'(q_read_num) * RB
                             + int'(pos_in) / SYM_ROW);

    assign issue = q_valid
                && (q_status != ST_DONE)
                && (q_status != ST_F_BREAK);
    assign oor   = (int'(q_pos) >= MAX_LEN)
                || ({1'b0, q_read_num} >= batch_size);

    always_comb begin
        s1_v_d    = issue;
        s1_oor_d  = oor;
        s1_pos_d  = q_pos;
        s1_row_d  = row_data;

        s2_v_d    = s1_v_q;
        s2_oor_d  = s1_oor_q;
        s2_pos_d  = s1_pos_q;
        s2_word_d = s1_row_q[int'(s1_pos_q[COL_W-1:3]) * 64 +: 64];

        out_v_d   = s2_v_q;
        out_pos_d = s2_pos_q;
        out_sym_d = 8'hFF;
        if (s2_v_q && !s2_oor_q) begin
            out_sym_d = s2_word_q[int'(s2_pos_q[2:0]) * 8 +: 8];
        end

        if (flush) begin
            s1_v_d    = 1'b0;
            s2_v_d    = 1'b0;
            out_v_d   = 1'b0;
            out_sym_d = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_pos_q  <= '0;
            s1_row_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_oor_q  <= 1'b0;
            s2_pos_q  <= '0;
            s2_word_q <= '0;
            out_v_q   <= 1'b0;
            out_sym_q <= 8'hFF;
            out_pos_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_oor_q  <= s1_oor_d;
            s1_pos_q  <= s1_pos_d;
            s1_row_q  <= s1_row_d;
            s2_v_q    <= s2_v_d;
            s2_oor_q  <= s2_oor_d;
            s2_pos_q  <= s2_pos_d;
            s2_word_q <= s2_word_d;
            out_v_q   <= out_v_d;
            out_sym_q <= out_sym_d;
            out_pos_q <= out_pos_d;
        end
    end

    assign q_out_valid = out_v_q;
    assign q_out_sym   = out_sym_q;
    assign q_out_pos   = out_pos_q;

endmodule

// File: rtl/smem_read_store.sv
// smem_read_store: batch store for SMEM reads with beat loading,
// one-by-one read dispatch and NQ independent symbol-query lanes.
module smem_read_store
    import smem_pkg::*;
#(
    parameter int CL       = 512,
    parameter int MAX_READ = 512,
    parameter int MAX_LEN  = 128,
    parameter int NQ       = 2,
    parameter int RN_W     = $clog2(MAX_READ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 restart,
    input  logic [RN_W:0]        batch_size,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CL-1:0]        load_data,
    output logic                 load_done,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [RN_W-1:0]      rd_num,
    output logic [63:0]          rd_ik_x0,
    output logic [63:0]          rd_ik_x1,
    output logic [63:0]          rd_ik_x2,
    output logic [63:0]          rd_ik_info,
    output logic [6:0]           rd_forward_i,
    output logic                 dispatch_done,
    input  logic [NQ-1:0]        q_valid,
    input  logic [6*NQ-1:0]      q_status,
    input  logic [8*NQ-1:0]      q_pos,
    input  logic [RN_W*NQ-1:0]   q_read_num,
    output logic [NQ-1:0]        q_out_valid,
    output logic [8*NQ-1:0]      q_out_sym,
    output logic [8*NQ-1:0]      q_out_pos,
    output logic [63:0]          primary,
    output logic [63:0]          l2_0,
    output logic [63:0]          l2_1,
    output logic [63:0]          l2_2,
    output logic [63:0]          l2_3
);

    localparam int RB    = MAX_LEN * 8 / CL;
    localparam int BEATS = RB + 2;
    localparam int BC_W  = $clog2(BEATS);
    localparam int ROWS  = MAX_READ * RB;
    localparam int ROW_W = $clog2(ROWS);

    logic [CL-1:0]        sym_mem [ROWS];
    logic [PAR_FWD_W-1:0] fwd_mem [MAX_READ];
    logic [IK_ROW_W-1:0]  ik_mem  [MAX_READ];

    logic [RN_W:0]        wr_ptr_q, wr_ptr_d;
    logic [BC_W-1:0]      beat_q, beat_d;
    logic                 load_done_q, load_done_d;
    logic [PAR_PRI_W-1:0] primary_q, primary_d;
    logic [IK_L2_W-1:0]   l2_q, l2_d;

    logic [RN_W-1:0]      wr_idx;
    logic [ROW_W-1:0]     sym_waddr;
    logic                 load_full;
    logic                 load_wr;
    logic                 is_par;
    logic                 is_ik;

    assign wr_idx    = wr_ptr_q[RN_W-1:0];
    assign sym_waddr = ROW_W'(int'(wr_idx) * RB + int'(beat_q));
    assign load_full = (batch_size != '0) && (wr_ptr_q == batch_size);
    assign load_ready = !load_full;
    // an empty batch never fills, so its beats are swallowed unwritten
    assign load_wr   = load_valid && !load_full && reset_n
                    && !restart && (batch_size != '0);
    assign is_par    = (beat_q == BC_W'(RB));
    assign is_ik     = (beat_q == BC_W'(RB + 1));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        beat_d      = beat_q;
        load_done_d = load_done_q | load_full;
        primary_d   = primary_q;
        l2_d        = l2_q;
        if (load_wr) begin
            if (is_ik) begin
                beat_d   = '0;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
            if (wr_ptr_q == '0 && is_par) begin
                primary_d = load_data[PAR_PRI_LSB +: PAR_PRI_W];
            end
            if (wr_ptr_q == '0 && is_ik) begin
                l2_d = load_data[IK_L2_LSB +: IK_L2_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            beat_q      <= '0;
            load_done_q <= 1'b0;
            primary_q   <= '0;
            l2_q        <= '0;
        end else if (restart) begin
            wr_ptr_q    <= '0;
            beat_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            beat_q      <= beat_d;
            load_done_q <= load_done_d;
            primary_q   <= primary_d;
            l2_q        <= l2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_wr && !is_par && !is_ik) begin
            sym_mem[sym_waddr] <= load_data;
        end
        if (load_wr && is_par) begin
            fwd_mem[wr_idx] <= load_data[PAR_FWD_LSB +: PAR_FWD_W];
        end
        if (load_wr && is_ik) begin
            ik_mem[wr_idx] <= load_data[IK_ROW_W-1:0];
        end
    end

    disp_state_e          dstate_q, dstate_d;
    logic [RN_W:0]        rd_ptr_q, rd_ptr_d;
    logic [RN_W:0]        rd_ptr_nxt;
    logic                 rd_valid_q, rd_valid_d;
    logic [RN_W-1:0]      rd_num_q, rd_num_d;
    logic [IK_ROW_W-1:0]  rd_ik_q, rd_ik_d;
    logic [PAR_FWD_W-1:0] rd_fwd_q, rd_fwd_d;
    logic                 disp_done_q, disp_done_d;

    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    always_comb begin
        dstate_d    = dstate_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_valid_q;
        rd_num_d    = rd_num_q;
        rd_ik_d     = rd_ik_q;
        rd_fwd_d    = rd_fwd_q;
        disp_done_d = disp_done_q;
        unique case (dstate_q)
            DS_IDLE: begin
                if (load_done_q) begin
                    dstate_d = DS_FETCH;
                end
            end
            DS_FETCH: begin
                rd_valid_d = 1'b1;
                rd_num_d   = rd_ptr_q[RN_W-1:0];
                rd_ik_d    = ik_mem[rd_ptr_q[RN_W-1:0]];
                rd_fwd_d   = fwd_mem[rd_ptr_q[RN_W-1:0]];
                dstate_d   = DS_SHOW;
            end
            DS_SHOW: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_ptr_d   = rd_ptr_nxt;
                    if (rd_ptr_nxt >= batch_size) begin
                        dstate_d    = DS_DONE;
                        disp_done_d = 1'b1;
                    end else begin
                        dstate_d = DS_FETCH;
                    end
                end
            end
            DS_DONE: begin
                rd_valid_d = 1'b0;
            end
            default: begin
                dstate_d = DS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dstate_q    <= DS_IDLE;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_num_q    <= '0;
            rd_ik_q     <= '0;
            rd_fwd_q    <= '0;
            disp_done_q <= 1'b0;
        end else if (restart) begin
            dstate_q    <= DS_IDLE;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            disp_done_q <= 1'b0;
        end else begin
            dstate_q    <= dstate_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_num_q    <= rd_num_d;
            rd_ik_q     <= rd_ik_d;
            rd_fwd_q    <= rd_fwd_d;
            disp_done_q <= disp_done_d;
        end
    end

    assign load_done     = load_done_q;
    assign rd_valid      = rd_valid_q;
    assign rd_num        = rd_num_q;
    assign rd_ik_x0      = rd_ik_q[63:0];
    assign rd_ik_x1      = rd_ik_q[127:64];
    assign rd_ik_x2      = rd_ik_q[191:128];
    assign rd_ik_info    = rd_ik_q[255:192];
    assign rd_forward_i  = rd_fwd_q;
    assign dispatch_done = disp_done_q;
    assign primary       = primary_q;
    assign l2_0          = l2_q[63:0];
    assign l2_1          = l2_q[127:64];
    assign l2_2          = l2_q[191:128];
    assign l2_3          = l2_q[255:192];

    logic [ROW_W-1:0] lane_addr [NQ];
    logic [CL-1:0]    lane_row  [NQ];

    // each lane gets its own read port; the RAM is replicated per lane
    for (genvar g = 0; g < NQ; g++) begin : g_lane
        assign lane_row[g] = sym_mem[lane_addr[g]];

        smem_query_lane #(
            .CL      (CL),
            .MAX_LEN (MAX_LEN),
            .RN_W    (RN_W),
            .RB      (RB),
            .ROW_W   (ROW_W)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush       (restart),
            .batch_size  (batch_size),
            .q_valid     (q_valid[g]),
            .q_status    (q_status[6*g +: 6]),
            .q_pos       (q_pos[8*g +: 8]),
            .q_read_num  (q_read_num[RN_W*g +: RN_W]),
            .row_addr    (lane_addr[g]),
            .row_data    (lane_row[g]),
            .q_out_valid (q_out_valid[g]),
            .q_out_sym   (q_out_sym[8*g +: 8]),
            .q_out_pos   (q_out_pos[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_smem_read_store.sv
// tb_smem_read_store: randomized self-checking bench for smem_read_store
// against a read/symbol array model of the batch contents.
module tb_smem_read_store;

    localparam int CL      = 512;
    localparam int MAX_LEN = 128;
    localparam int NQ      = 2;
    localparam int RN_W    = 9;
    localparam int RB      = 2;
    localparam int BPR     = RB + 2;
    localparam int NRQ     = 40;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              restart;
    logic [RN_W:0]     batch_size;
    logic              load_valid;
    logic              load_ready;
    logic [CL-1:0]     load_data;
    logic              load_done;
    logic              rd_valid;
    logic              rd_ready;
    logic [RN_W-1:0]   rd_num;
    logic [63:0]       rd_ik_x0, rd_ik_x1, rd_ik_x2, rd_ik_info;
    logic [6:0]        rd_forward_i;
    logic              dispatch_done;
    logic [NQ-1:0]     q_valid;
    logic [6*NQ-1:0]   q_status;
    logic [8*NQ-1:0]   q_pos;
    logic [RN_W*NQ-1:0] q_read_num;
    logic [NQ-1:0]     q_out_valid;
    logic [8*NQ-1:0]   q_out_sym;
    logic [8*NQ-1:0]   q_out_pos;
    logic [63:0]       primary, l2_0, l2_1, l2_2, l2_3;

    int errors = 0;
    int checks = 0;

    logic [7:0]    msym [8][MAX_LEN];
    logic [CL-1:0] mpar [8];
    logic [CL-1:0] mik  [8];

    smem_read_store dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .restart       (restart),
        .batch_size    (batch_size),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_done     (load_done),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_num        (rd_num),
        .rd_ik_x0      (rd_ik_x0),
        .rd_ik_x1      (rd_ik_x1),
        .rd_ik_x2      (rd_ik_x2),
        .rd_ik_info    (rd_ik_info),
        .rd_forward_i  (rd_forward_i),
        .dispatch_done (dispatch_done),
        .q_valid       (q_valid),
        .q_status      (q_status),
        .q_pos         (q_pos),
        .q_read_num    (q_read_num),
        .q_out_valid   (q_out_valid),
        .q_out_sym     (q_out_sym),
        .q_out_pos     (q_out_pos),
        .primary       (primary),
        .l2_0          (l2_0),
        .l2_1          (l2_1),
        .l2_2          (l2_2),
        .l2_3          (l2_3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [CL-1:0] rnd_row();
        logic [CL-1:0] r;
        for (int i = 0; i < CL / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_model(input bit rnd);
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < MAX_LEN; i++)
                msym[n][i] = rnd ? 8'($urandom) : 8'(n * 16 + i);
            mpar[n] = rnd_row();
            mik[n]  = rnd_row();
        end
    endtask

    function automatic logic [CL-1:0] mk_beat(input int b);
        logic [CL-1:0] r;
        int n;
        int k;
        n = b / BPR;
        k = b % BPR;
        r = '0;
        if (k < RB) begin
            for (int j = 0; j < CL / 8; j++)
                r[8*j +: 8] = msym[n][k * (CL / 8) + j];
        end else if (k == RB) begin
            r = mpar[n];
        end else begin
            r = mik[n];
        end
        return r;
    endfunction

    // {valid, sym} the store should answer for one query
    function automatic logic [8:0] model_q(input bit v, input logic [5:0] st,
                                           input int pos, input int rn,
                                           input int bs);
        if (!v || st == 6'd2 || st == 6'h3F) return {1'b0, 8'hFF};
        if (pos >= MAX_LEN || rn >= bs) return {1'b1, 8'hFF};
        return {1'b1, msym[rn][pos]};
    endfunction

    task automatic set_q(input int ch, input bit v, input logic [5:0] st,
                         input int pos, input int rn);
        q_valid[ch]               = v;
        q_status[6*ch +: 6]       = st;
        q_pos[8*ch +: 8]          = 8'(pos);
        q_read_num[RN_W*ch +: RN_W] = RN_W'(rn);
    endtask

    task automatic load_beats(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                step();
            end
            load_valid = 1'b1;
            load_data  = mk_beat(b);
            checks++;
            if (load_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready beat %0d: got %b want 1", b, load_ready);
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; restart = 1'b0; batch_size = 10'd3;
        load_valid = 1'b0; load_data = '0; rd_ready = 1'b0;
        q_valid = '0; q_status = '0; q_pos = '0; q_read_num = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL reset load_ready: got %b want 1", load_ready);
        end
        checks++;
        if ({load_done, rd_valid, dispatch_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags: got %b%b%b want 000", load_done, rd_valid, dispatch_done);
        end
        checks++;
        if (q_out_valid !== 2'b00 || q_out_sym !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset query: got v=%b s=%h want v=00 s=ffff", q_out_valid, q_out_sym);
        end
        checks++;
        if (primary !== 64'd0 || l2_0 !== 64'd0 || rd_num !== '0) begin
            errors++; $display("FAIL reset data: got primary=%h l2_0=%h want 0", primary, l2_0);
        end
    endtask

    task automatic test_load();
        load_beats(3 * BPR);
        checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_full: got ready=%b done=%b want 0 0", load_ready, load_done);
        end
        load_valid = 1'b1;
        load_data  = rnd_row();
        step();
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1) begin
            errors++; $display("FAIL load_done: got %b want 1", load_done);
        end
        checks++;
        if (primary !== mpar[0][191:128]) begin
            errors++; $display("FAIL primary: got %h want %h", primary, mpar[0][191:128]);
        end
        checks++;
        if ({l2_3, l2_2, l2_1, l2_0} !== mik[0][511:256]) begin
            errors++; $display("FAIL l2: got %h want %h", {l2_3, l2_2, l2_1, l2_0}, mik[0][511:256]);
        end
    endtask

    task automatic test_dispatch(input int nreads);
        int exp_n;
        rd_ready = 1'b0;
        for (int i = 0; i < 20 && !rd_valid; i++) step();
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++; $display("FAIL dispatch_start: got rd_valid=%b want 1", rd_valid);
        end
        for (int h = 0; h < 2; h++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_num !== '0) begin
                errors++;
                $display("FAIL dispatch_hold: got v=%b num=%0d want 1 0", rd_valid, rd_num);
            end
        end
        exp_n = 0;
        for (int c = 0; c < 200 && exp_n < nreads; c++) begin
            rd_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rd_valid && rd_ready) begin
                checks++;
                if (rd_num !== RN_W'(exp_n)
                    || {rd_ik_info, rd_ik_x2, rd_ik_x1, rd_ik_x0} !== mik[exp_n][255:0]
                    || rd_forward_i !== mpar[exp_n][6:0]) begin
                    errors++;
                    $display("FAIL dispatch_read: got num=%0d fwd=%h x0=%h want num=%0d fwd=%h x0=%h",
                             rd_num, rd_forward_i, rd_ik_x0, exp_n, mpar[exp_n][6:0], mik[exp_n][63:0]);
                end
                exp_n++;
            end
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (exp_n != nreads) begin
            errors++; $display("FAIL dispatch_count: got %0d want %0d", exp_n, nreads);
        end
        checks++;
        if (rd_valid !== 1'b0 || dispatch_done !== 1'b1) begin
            errors++;
            $display("FAIL dispatch_end: got v=%b done=%b want 0 1", rd_valid, dispatch_done);
        end
    endtask

    task automatic test_query_fixed();
        set_q(0, 1'b1, 6'd0, 5, 1);
        set_q(1, 1'b1, 6'd0, 100, 2);
        step();
        q_valid = '0;
        step(); step();
        checks++;
        if (q_out_valid !== 2'b11 || q_out_sym !== 16'h8415 || q_out_pos !== {8'd100, 8'd5}) begin
            errors++;
            $display("FAIL query_fixed: got v=%b s=%h p=%h want v=11 s=8415 p=6405",
                     q_out_valid, q_out_sym, q_out_pos);
        end
        set_q(0, 1'b1, 6'h3F, 3, 0);
        set_q(1, 1'b1, 6'd2, 3, 0);
        step();
        set_q(0, 1'b1, 6'd0, 130, 0);
        set_q(1, 1'b1, 6'd0, 4, 5);
        step();
        q_valid = '0;
        step();
        checks++;
        if (q_out_valid !== 2'b00 || q_out_sym !== 16'hFFFF) begin
            errors++;
            $display("FAIL query_bubble: got v=%b s=%h want v=00 s=ffff", q_out_valid, q_out_sym);
        end
        step();
        checks++;
        if (q_out_valid !== 2'b11 || q_out_sym !== 16'hFFFF) begin
            errors++;
            $display("FAIL query_range: got v=%b s=%h want v=11 s=ffff", q_out_valid, q_out_sym);
        end
    endtask

    task automatic test_query_random(input int bs);
        logic [8:0] ex [NRQ][NQ];
        logic [7:0] ep [NRQ][NQ];
        for (int c = 0; c < NRQ + 3; c++) begin
            if (c >= 3) begin
                for (int ch = 0; ch < NQ; ch++) begin
                    checks++;
                    if (q_out_valid[ch] !== ex[c-3][ch][8]
                        || q_out_sym[8*ch +: 8] !== ex[c-3][ch][7:0]
                        || (ex[c-3][ch][8] && q_out_pos[8*ch +: 8] !== ep[c-3][ch])) begin
                        errors++;
                        $display("FAIL query_rand c%0d ch%0d: got v=%b s=%h p=%0d want v=%b s=%h p=%0d",
                                 c - 3, ch, q_out_valid[ch], q_out_sym[8*ch +: 8],
                                 q_out_pos[8*ch +: 8], ex[c-3][ch][8], ex[c-3][ch][7:0],
                                 ep[c-3][ch]);
                    end
                end
            end
            if (c < NRQ) begin
                for (int ch = 0; ch < NQ; ch++) begin
                    bit v;
                    int r;
                    logic [5:0] st;
                    int pos;
                    int rn;
                    v   = 1'($urandom_range(0, 3) != 0);
                    r   = $urandom_range(0, 5);
                    st  = (r == 4) ? 6'd2 : (r == 5) ? 6'h3F : 6'(r);
                    pos = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255)
                                                      : $urandom_range(0, 127);
                    rn  = $urandom_range(0, 4);
                    set_q(ch, v, st, pos, rn);
                    ex[c][ch] = model_q(v, st, pos, rn, bs);
                    ep[c][ch] = 8'(pos);
                end
            end else begin
                q_valid = '0;
            end
            step();
        end
        q_valid = '0;
    endtask

    task automatic test_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({load_ready, load_done, dispatch_done, rd_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL restart_flags: got %b%b%b%b want 1000",
                     load_ready, load_done, dispatch_done, rd_valid);
        end
        fill_model(1'b1);
        load_beats(5);
        set_q(0, 1'b1, 6'd0, 0, 0);
        step();
        q_valid = '0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        checks++;
        if (q_out_valid[0] !== 1'b0 || q_out_sym[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL restart_flush: got v=%b s=%h want v=0 s=ff", q_out_valid[0], q_out_sym[7:0]);
        end
        fill_model(1'b1);
        test_load();
        test_dispatch(3);
        test_query_random(3);
    endtask

    task automatic test_zero_batch();
        batch_size = '0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        for (int b = 0; b < 16; b++) begin
            load_valid = (b < 10);
            load_data  = rnd_row();
            step();
            checks++;
            if (load_done !== 1'b0 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_batch %0d: got done=%b v=%b want 0 0", b, load_done, rd_valid);
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        fill_model(1'b0);
        test_reset();
        test_load();
        test_dispatch(3);
        test_query_fixed();
        test_query_random(3);
        test_restart();
        test_zero_batch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
